// File: rtl/rf_pulse_monitor.sv
// Measures every high/low interval on rf and rabi and queues tagged records {chan, level, sat, count}.
// Record reaches the FIFO 3 cycles after the input is sampled; a full FIFO parks records in a 1-deep hold per channel, further ones drop and set overflow.
module rf_pulse_monitor #(
  parameter int CNT_W = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rf_in,
  input  logic             rabi_in,
  input  logic             clr,
  input  logic             rd_en,
  output logic [CNT_W+2:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [AW:0]      PTR_ONE = 1;

  logic [1:0]       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]       armed_q, armed_d, sat_q, sat_d, hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [RW-1:0]    hold_q [2];
  logic [RW-1:0]    hold_d [2];
  logic [RW-1:0]    mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [RW-1:0]    rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d, empty_q, empty_d, full_q, full_d;
  logic             overflow_q, overflow_d;
  logic [1:0]       edge_det;
  logic             wr_en, rd_fire, wr_sel;
  logic [RW-1:0]    wr_dat;

  always_comb begin
    s1_d       = {rabi_in, rf_in};
    s2_d       = s1_q;
    s3_d       = s2_q;
    edge_det   = s2_q ^ s3_q;
    overflow_d = overflow_q;
    // rf hold has priority; a read in the same cycle frees a slot even when full
    wr_sel     = ~hold_vld_q[0];
    wr_en      = (|hold_vld_q) && (!full_q || rd_en) && !clr;
    rd_fire    = rd_en && !empty_q && !clr;
    wr_dat     = hold_q[wr_sel];
    for (int c = 0; c < 2; c++) begin
      armed_d[c]    = armed_q[c];
      cnt_d[c]      = cnt_q[c];
      sat_d[c]      = sat_q[c];
      hold_vld_d[c] = hold_vld_q[c];
      hold_d[c]     = hold_q[c];
      if (wr_en && (wr_sel == c[0])) hold_vld_d[c] = 1'b0;
      if (edge_det[c]) begin
        armed_d[c] = 1'b1;
        cnt_d[c]   = CNT_ONE;
        sat_d[c]   = 1'b0;
        if (armed_q[c]) begin
          if (hold_vld_d[c]) begin
            overflow_d = 1'b1;
          end else begin
            hold_vld_d[c] = 1'b1;
            hold_d[c]     = {c[0], s3_q[c], sat_q[c], cnt_q[c]};
          end
        end
      end else if (armed_q[c]) begin
        // sat marks an interval longer than the counter can represent
        if (cnt_q[c] == CNT_MAX) sat_d[c] = 1'b1;
        else                     cnt_d[c] = cnt_q[c] + CNT_ONE;
      end
      if (clr) begin
        armed_d[c]    = 1'b0;
        cnt_d[c]      = '0;
        sat_d[c]      = 1'b0;
        hold_vld_d[c] = 1'b0;
      end
    end
    if (clr) overflow_d = 1'b0;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_fire) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
    end
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    rd_valid_d = rd_fire;
    empty_d    = (wr_ptr_d == rd_ptr_d);
    full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      armed_q    <= '0;
      sat_q      <= '0;
      hold_vld_q <= '0;
      for (int c = 0; c < 2; c++) begin
        cnt_q[c]  <= '0;
        hold_q[c] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      armed_q    <= armed_d;
      sat_q      <= sat_d;
      hold_vld_q <= hold_vld_d;
      for (int c = 0; c < 2; c++) begin
        cnt_q[c]  <= cnt_d[c];
        hold_q[c] <= hold_d[c];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // storage only; occupancy is tracked by the reset pointers
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_rf_pulse_monitor.sv
// Scoreboard bench: an interval model predicts records per input run; monitors pop on rd_valid.
module tb_rf_pulse_monitor;
  typedef struct packed {
    bit          chan;
    bit          level;
    bit          sat;
    int unsigned count;
  } rec_t;

  logic        clk;
  logic        rst_n;
  logic        rf_a, rabi_a, clr_a, rd_en_a;
  logic        rf_b, rabi_b, clr_b, rd_en_b;
  logic [34:0] rd_data_a;
  logic [10:0] rd_data_b;
  logic        rd_valid_a, empty_a, full_a, overflow_a;
  logic        rd_valid_b, empty_b, full_b, overflow_b;

  int          errors = 0;
  int          checks = 0;
  int          rd_mode_a = 0;
  int          rd_mode_b = 0;
  rec_t        exp_a[$];
  rec_t        exp_b[$];
  bit          cur   [2][2];
  bit          last  [2][2];
  bit          armed [2][2];
  int unsigned run   [2][2];
  int unsigned maxv  [2] = '{32'hFFFF_FFFF, 255};

  rf_pulse_monitor u_a (
    .clk(clk), .rst_n(rst_n), .rf_in(rf_a), .rabi_in(rabi_a), .clr(clr_a), .rd_en(rd_en_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .empty(empty_a), .full(full_a), .overflow(overflow_a)
  );

  rf_pulse_monitor #(.CNT_W(8), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .rf_in(rf_b), .rabi_in(rabi_b), .clr(clr_b), .rd_en(rd_en_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .empty(empty_b), .full(full_b), .overflow(overflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic rec_t mk(input bit ch, input bit lv, input bit st, input int unsigned cnt);
    rec_t r;
    r.chan  = ch;
    r.level = lv;
    r.sat   = st;
    r.count = cnt;
    return r;
  endfunction

  // interval model: a run of N identical samples ending in a change yields one record
  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (cur[i][c] != last[i][c]) begin
          if (armed[i][c]) begin
            rec_t r;
            r = mk(c[0], last[i][c], run[i][c] > maxv[i],
                   (run[i][c] > maxv[i]) ? maxv[i] : run[i][c]);
            if (i == 0) exp_a.push_back(r);
            else        exp_b.push_back(r);
          end
          armed[i][c] = 1'b1;
          run[i][c]   = 1;
          last[i][c]  = cur[i][c];
        end else begin
          run[i][c]++;
        end
      end
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      rf_a   = cur[0][0];
      rabi_a = cur[0][1];
      rf_b   = cur[1][0];
      rabi_b = cur[1][1];
      @(posedge clk);
      #1;
      model_tick();
    end
  endtask

  task automatic clear_b();
    clr_b = 1'b1;
    tick(1);
    clr_b = 1'b0;
    exp_b.delete();
    armed[1][0] = 1'b0;
    armed[1][1] = 1'b0;
  endtask

  task automatic reader();
    forever begin
      @(posedge clk);
      #2;
      rd_en_a = (rd_mode_a == 1) || ((rd_mode_a == 2) && ($urandom_range(0, 1) == 1));
      rd_en_b = (rd_mode_b == 1) || ((rd_mode_b == 2) && ($urandom_range(0, 1) == 1));
    end
  endtask

  task automatic mon_a();
    rec_t e;
    forever begin
      @(negedge clk);
      if (rd_valid_a) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rec_a: got %0h expected none at %0t", rd_data_a, $time);
        end else begin
          e = exp_a.pop_front();
          chk("rec_a", 64'(rd_data_a), 64'({e.chan, e.level, e.sat, e.count}));
        end
      end
    end
  endtask

  task automatic mon_b();
    rec_t e;
    forever begin
      @(negedge clk);
      if (rd_valid_b) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rec_b: got %0h expected none at %0t", rd_data_b, $time);
        end else begin
          e = exp_b.pop_front();
          chk("rec_b", 64'(rd_data_b), 64'({e.chan, e.level, e.sat, e.count[7:0]}));
        end
      end
    end
  endtask

  initial begin
    int rem [2];
    rst_n = 1'b0;
    {rf_a, rabi_a, clr_a, rd_en_a, rf_b, rabi_b, clr_b, rd_en_b} = '0;
    fork
      reader();
      mon_a();
      mon_b();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_data_a", 64'(rd_data_a), 64'(0));
    chk("rst_rd_valid_a", 64'(rd_valid_a), 64'(0));
    chk("rst_empty_a", 64'(empty_a), 64'(1));
    chk("rst_full_a", 64'(full_a), 64'(0));
    chk("rst_overflow_a", 64'(overflow_a), 64'(0));
    chk("rst_empty_b", 64'(empty_b), 64'(1));
    chk("rst_full_b", 64'(full_b), 64'(0));
    chk("rst_overflow_b", 64'(overflow_b), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // b: DEPTH=4 overflow, no reads; toggle rf every 10 cycles 8 times
    for (int t = 0; t < 8; t++) begin
      cur[1][0] = !cur[1][0];
      tick(10);
    end
    chk("ovf_full_b", 64'(full_b), 64'(1));
    chk("ovf_flag_b", 64'(overflow_b), 64'(1));
    chk("ovf_empty_b", 64'(empty_b), 64'(0));
    exp_b.delete();
    for (int t = 0; t < 5; t++) exp_b.push_back(mk(1'b0, (t % 2) == 0, 1'b0, 10));

    // a: directed rf sequence, random reads
    rd_mode_a = 2;
    tick(100);
    cur[0][0] = 1'b1; tick(333);
    cur[0][0] = 1'b0; tick(33300);
    cur[0][0] = 1'b1; tick(666);
    cur[0][0] = 1'b0; tick(20);

    // b: drain the overflowed FIFO: 4 records plus the held one
    rd_mode_b = 1;
    tick(15);
    chk("ovf_drain_empty_b", 64'(empty_b), 64'(1));
    chk("ovf_drain_left_b", 64'(exp_b.size()), 64'(0));

    clear_b();
    chk("clr_empty_b", 64'(empty_b), 64'(1));
    chk("clr_overflow_b", 64'(overflow_b), 64'(0));

    // b: saturation at CNT_W=8, then a short interval with sat clear
    cur[1][0] = 1'b1; tick(300);
    cur[1][0] = 1'b0; tick(20);
    cur[1][0] = 1'b1; tick(15);

    // a: identical edges on rf and rabi
    for (int t = 0; t < 10; t++) begin
      cur[0][0] = !cur[0][0];
      cur[0][1] = !cur[0][1];
      tick($urandom_range(8, 40));
    end
    tick(20);
    chk("simul_overflow_a", 64'(overflow_a), 64'(0));

    // b: fill to full, then one record and one read per cycle
    rd_mode_b = 0;
    tick(2);
    for (int t = 0; t < 4; t++) begin
      cur[1][0] = !cur[1][0];
      tick(5);
    end
    tick(10);
    chk("fill_full_b", 64'(full_b), 64'(1));
    for (int i = 0; i < 16; i++) begin
      cur[1][0] = !cur[1][0];
      if (i == 3) rd_mode_b = 1;
      tick(1);
      chk("rw_full_b", 64'(full_b), 64'(1));
      if (i >= 3) chk("rw_valid_b", 64'(rd_valid_b), 64'(1));
    end
    tick(20);
    chk("rw_empty_b", 64'(empty_b), 64'(1));
    chk("rw_overflow_b", 64'(overflow_b), 64'(0));
    chk("rw_left_b", 64'(exp_b.size()), 64'(0));

    // b: mid-stream flush after forcing an overflow
    rd_mode_b = 0;
    tick(2);
    for (int t = 0; t < 8; t++) begin
      cur[1][0] = !cur[1][0];
      tick(6);
    end
    chk("pre_flush_ovf_b", 64'(overflow_b), 64'(1));
    clear_b();
    chk("flush_empty_b", 64'(empty_b), 64'(1));
    chk("flush_overflow_b", 64'(overflow_b), 64'(0));
    chk("flush_full_b", 64'(full_b), 64'(0));
    rd_mode_b = 1;
    cur[1][0] = !cur[1][0]; tick(12);
    cur[1][0] = !cur[1][0]; tick(12);
    cur[1][0] = !cur[1][0]; tick(10);
    chk("flush_left_b", 64'(exp_b.size()), 64'(0));
    chk("flush_end_empty_b", 64'(empty_b), 64'(1));

    // a: independent random intervals on both channels
    rem[0] = $urandom_range(8, 60);
    rem[1] = $urandom_range(8, 60);
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          cur[0][c] = !cur[0][c];
          rem[c] = $urandom_range(8, 60);
        end else begin
          rem[c]--;
        end
      end
      tick(1);
    end
    rd_mode_a = 1;
    tick(40);
    chk("end_empty_a", 64'(empty_a), 64'(1));
    chk("end_overflow_a", 64'(overflow_a), 64'(0));
    chk("end_left_a", 64'(exp_a.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_pulse_monitor.md
# rf_pulse_monitor

Cycle-accurate timing monitor placed downstream of the pulse sequencer. It watches the Mach-Zehnder output (`rf`) and the Raman scan output (`rabi`) and measures the duration of every high and low interval. Each completed interval becomes a tagged record in a small FIFO, which the Arduino host drains through a read handshake. This lets the host confirm pulse lengths (pi, pi/2, T, scan steps) without a scope.

## Interface
Parameters:
- `CNT_W`, default 32: interval counter width.
- `DEPTH`, default 16: FIFO depth. Must be a power of 2 and at least 2.

Ports:
- `clk`, input, 1 bit: system clock.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `rf_in`, input, 1 bit: monitored MZ pulse line. May be asynchronous.
- `rabi_in`, input, 1 bit: monitored Raman scan line. May be asynchronous.
- `clr`, input, 1 bit: synchronous flush.
- `rd_en`, input, 1 bit: read request from the host.
- `rd_data`, output, CNT_W+3 bits: record `{chan, level, sat, count[CNT_W-1:0]}`.
- `rd_valid`, output, 1 bit: one-cycle strobe; `rd_data` is valid while it is high.
- `empty`, output, 1 bit: FIFO empty.
- `full`, output, 1 bit: FIFO full.
- `overflow`, output, 1 bit: sticky flag, set when any record is lost.

## Operation
- **Per-channel front end.**
  - Two-flop synchronizer (`s1`, `s2`) feeds a previous-value flop `s3`.
  - An edge is detected when `s2 != s3`.
- **Arming.**
  - After reset or `clr`, a channel is disarmed.
  - The first edge only arms the channel and clears its counter. No record is produced.
- **Counter.**
  - Loaded to 1 in the cycle an edge is detected, then incremented by 1 every cycle.
  - Saturates at 2^CNT_W−1. On saturation a per-channel `sat` bit is set; it is cleared on the next edge.
- **Record on each armed edge.**
  - `chan`: 0 for rf, 1 for rabi.
  - `level`: the level that just ended, i.e. `s3`.
  - `sat`: current `sat` bit.
  - `count`: current counter value.
  - Result: a level held for N cycles yields `count = N`.
- **Hold registers.** Each channel has a 1-deep hold register.
  - A new record is loaded into the hold register when the edge is detected.
  - If that channel's hold register is still occupied, the new record is dropped and `overflow` is set.
- **FIFO writer.** At most one write per cycle, with priority rf hold, then rabi hold.
  - Write only when `!full || rd_en`.
  - A hold register clears in the cycle its record is written.
- **Read.**
  - `rd_en` with `!empty`: pop; `rd_data` is registered and `rd_valid` pulses in the next cycle.
  - `rd_en` with `empty`: ignored; no `rd_valid`.
  - `rd_data` holds its last value between reads.
- **Simultaneous events.**
  - Read and write in the same cycle: occupancy unchanged. Allowed when full.
  - Write while empty with `rd_en` asserted: the read is ignored that cycle.
  - FIFO full with no read: the hold register stays occupied. Further edges on that channel drop records and set `overflow`.
- **`clr`.** Empties the FIFO, clears both hold registers, `overflow` and `sat`, and disarms both channels.
  - Synchronizer flops are not cleared.
  - `clr` takes priority over the same-cycle write and read.

## Timing
- **Reset values.** `rd_data` = 0, `rd_valid` = 0, `empty` = 1, `full` = 0, `overflow` = 0. Synchronizers = 0, counters = 0, channels disarmed.
- **Latency.** Let clock edge k be the edge that first samples the new input level.
  - Edge detected in the cycle after edge k+1.
  - Hold register loaded at k+2.
  - FIFO written at k+3, with no contention; `empty` falls after k+3.
  - If both channels produce records in the same cycle, rabi is written at k+4.
- **Read latency.** 1 cycle from `rd_en` to `rd_valid`.
- **Minimum resolvable interval.** 1 cycle. Counts are exact for intervals of at least 1 cycle after synchronization.
- **FIFO pointers.** log2(DEPTH)+1 bits, wrapping.
  - `full` when the pointer MSBs differ and the low bits are equal.
  - `full` and `empty` are registered and updated in the same cycle as the pointers.
- **Reset mid-operation.** Asynchronous clear of all state. No record is emitted for a partially measured interval.

## Test plan
- **Reset, then rf sequence.** Apply reset, then drive rf low for 100 cycles, high for 333, low for 33300, high for 666. Pop records: 1st edge arms only; expect `{0,1,0,333}`, then `{0,0,0,33300}`, then `{0,1,0,666}` as the pulse ends.
- **Simultaneous edges.** Drive rf and rabi with identical edges. Expect each rf record immediately followed by the matching rabi record with the same count; `overflow` stays 0.
- **Saturation.** With `CNT_W`=8, hold rf high for 300 cycles. Expect the record `{0,1,1,255}`. The next interval has `sat`=0.
- **Overflow.** With `DEPTH`=4 and no reads, toggle rf every 10 cycles 8 times. Expect `full`=1 and `overflow`=1. Draining yields 4 records with count 10 plus 1 held record, then `empty`=1.
- **Simultaneous read/write when full.** Assert `rd_en` every cycle while full and edges continue. Expect occupancy to stay at DEPTH, no drops, and one `rd_valid` per `rd_en`.
- **Mid-stream flush.** Assert `clr` mid-stream. Expect `empty`=1 and `overflow`=0 next cycle. The next edge arms only, and the edge after it produces a correct count.
